// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   - state encoding for the start/run/done sequencer
//   - clog2 helper for counter sizing
//   - default operand width
package serial_arith_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    // Plain-vector views of the state encoding for legacy-style state registers.
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor, dataflow style: d = a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out (combinational)
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request, sampled when not busy (IDLE or DONE)
//   a, b, bin       : operands and borrow-in, captured on the accepted start
//   busy            : high while the subtraction is running
//   done            : one-cycle pulse, diff/bout (and ovf) valid
//   diff, bout      : registered result, held until the next completion
//   ovf             : signed overflow, only with SERIAL_SUBTRACTOR_OVERFLOW_EN
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (clog2(WIDTH + 1) < 1) ? 1 : clog2(WIDTH + 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_sr_nxt;
    logic             brw;
    logic             brw_nxt;
    logic             d_bit;
    logic [CNT_W-1:0] cnt;

`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
    logic             a_msb;
    logic             b_msb;
`endif

    // Single bit-step cell on the LSBs of the operand shift registers.
    full_subtractor_cell u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (brw),
        .d    (d_bit),
        .bout (brw_nxt)
    );

    // New difference bit enters at the MSB; the shift keeps WIDTH=1 legal.
    assign diff_sr_nxt = WIDTH'({d_bit, diff_sr} >> 1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and control decode; start is only honoured outside RUN.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == CNT_W'(WIDTH - 1)) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs. Results are written on the edge that
    // enters DONE so that diff/bout are valid in the same cycle as done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            a_sr    <= '0;
            b_sr    <= '0;
            diff_sr <= '0;
            brw     <= 1'b0;
            cnt     <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
            ovf     <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
`endif
        end else begin
            busy <= (state_nxt == ST_RUN);
            done <= (state_nxt == ST_DONE);
            if (load) begin
                a_sr  <= a;
                b_sr  <= b;
                brw   <= bin;
                cnt   <= '0;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                a_msb <= a[WIDTH-1];
                b_msb <= b[WIDTH-1];
`endif
            end else if (state == ST_RUN) begin
                a_sr    <= a_sr >> 1;
                b_sr    <= b_sr >> 1;
                brw     <= brw_nxt;
                diff_sr <= diff_sr_nxt;
                cnt     <= cnt + CNT_W'(1);
                if (last) begin
                    diff <= diff_sr_nxt;
                    bout <= brw_nxt;
`ifdef SERIAL_SUBTRACTOR_OVERFLOW_EN
                    // d_bit is the final (MSB) difference bit here.
                    ovf  <= (a_msb != b_msb) && (d_bit != a_msb);
`endif
                end
            end
        end
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; computes diff = a - b - bin, one bit per clock, LSB first.
- Registered companion to the dataflow full adder: performs the inverse operation (subtraction with borrow) over a full operand width.
- Used by datapath control, where area matters more than latency.
- Simple start/busy/done handshake; result is held until the next accepted start.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1 to 64).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when not busy
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- bin  input  1  borrow-in; captured on the accepted start
- busy  output  1  high while a subtraction is in progress
- done  output  1  one-cycle pulse when diff/bout are valid
- diff  output  WIDTH  difference, registered
- bout  output  1  final borrow-out, registered

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, diff=0, bout=0; shift registers, borrow flop and bit counter all 0.
- States:
  - IDLE: start=1 loads a_sr<=a, b_sr<=b, brw<=bin, cnt<=0 and moves to RUN.
  - RUN: each edge computes d_i = a_sr[0]^b_sr[0]^brw and brw <= (~a_sr[0]&b_sr[0]) | (~a_sr[0]&brw) | (b_sr[0]&brw). It right-shifts a_sr and b_sr, shifts d_i into diff_sr[WIDTH-1], and increments cnt. When cnt==WIDTH-1 it moves to DONE.
  - DONE: diff<=diff_sr, bout<=brw, done=1 for exactly this one cycle. Next state: RUN if start=1 (load as in IDLE), else IDLE.
- busy=1 in RUN only; busy and done are never high together.
- Latency: start is sampled at edge k; done is high in the cycle after edge k+WIDTH; back-to-back throughput is one result per WIDTH+1 cycles.
- start while in RUN is ignored: there is no queueing and the operands are not recaptured.
- Changes to a/b/bin after capture have no effect.
- diff/bout are updated only in DONE and hold their value through IDLE and subsequent RUNs.
- bout=1 exactly when the unsigned value a < b + bin.
- Wrap-around: the result is modulo 2^WIDTH (for example 0 - 1 = all ones).
- cnt width is clog2(WIDTH+1); WIDTH=1 gives a single RUN cycle.
- rst_n asserted mid-RUN aborts the operation immediately: no done, outputs cleared to their reset values.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVERFLOW_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0), updated in DONE alongside diff.
  - ovf = signed two's-complement overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).
  - a[MSB] and b[MSB] are kept in dedicated flops captured at start; the final-bit borrow-in is also registered.
- When undefined: no ovf port, no extra flops; the rest of the behaviour is identical.

Decomposition:
- Shared package serial_arith_pkg holds:
  - state enum (IDLE=2'b00, RUN=2'b01, DONE=2'b10)
  - counter-width function clog2
  - default WIDTH constant
- One combinational sub-module, full_subtractor_cell (a, b, bin -> d, bout), in dataflow style; instantiated once per bit step.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, pulse start -> done after 8+1 cycles; diff=0x1E, bout=0; busy high for exactly 8 cycles.
- a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1 (wrap-around); a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
- Start 0x5A-0x3C; at RUN cycle 3 apply start with a=0xFF, b=0x00 -> ignored; result 0x1E. Then hold start high through DONE with a=0xFF, b=0x00 -> done pulses twice, 9 cycles apart, giving 0x1E then 0xFF.
- Deassert rst_n at RUN cycle 4 -> diff=0, bout=0, busy=0, done never pulses. Release, then rerun 0x5A-0x3C -> 0x1E.
- With SERIAL_SUBTRACTOR_OVERFLOW_EN: 0x80-0x01 -> diff=0x7F, ovf=1, bout=0; 0x05-0x03 -> ovf=0; 0x7F-0xFF -> diff=0x80, ovf=1, bout=1.
- WIDTH=1 build: a=0, b=1, bin=1 -> diff=0, bout=1, done 2 cycles after start.
